// File: rtl/instr_mem_loader.sv
// Boot-time instruction store: fills word RAM from a length-prefixed byte
// stream and holds the core in reset until the image is complete.
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_val,
  output logic [31:0] instr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        load_req,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    RUN,
    ERR
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          nhi_q, nhi_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [23:0]         asm_q, asm_d;
  logic [31:0]         mem_q [DEPTH];

  logic                loading;
  logic                accept;
  logic                we;
  logic                last_word;
  logic [15:0]         n_hdr;
  logic [31:0]         wdata;
  logic                unused_pc;

  assign loading   = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                     (state_q == DATA);
  assign rx_ready  = loading & ~reset;
  assign cpu_reset = (state_q != RUN);
  assign done      = (state_q == RUN);
  assign err       = (state_q == ERR);

  assign accept    = rx_valid & rx_ready;
  assign n_hdr     = {nhi_q, rx_data};
  assign wdata     = {asm_q, rx_data};
  assign last_word = 32'(waddr_q) == (32'(n_q) - 32'd1);

  // Reads wrap modulo DEPTH; byte offset and high PC bits are dropped.
  assign instr     = done ? mem_q[pc_val[ADDR_W+1:2]] : 32'h0;
  assign unused_pc = ^{pc_val[31:ADDR_W+2], pc_val[1:0]};

  always_comb begin
    state_d = state_q;
    nhi_d   = nhi_q;
    n_d     = n_q;
    waddr_d = waddr_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    we      = 1'b0;
    unique case (state_q)
      HDR_HI: begin
        if (accept) begin
          nhi_d   = rx_data;
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          n_d     = n_hdr;
          waddr_d = '0;
          bidx_d  = '0;
          if (n_hdr == 16'd0) begin
            state_d = RUN;
          end else if (32'(n_hdr) > 32'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d = {asm_q[15:0], rx_data};
          if (bidx_q == 2'd3) begin
            we      = 1'b1;
            waddr_d = waddr_q + ADDR_W'(1);
            bidx_d  = 2'd0;
            if (last_word) begin
              state_d = RUN;
            end
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      RUN, ERR: begin
        if (load_req) begin
          state_d = HDR_HI;
        end
      end
      default: state_d = HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR_HI;
      nhi_q   <= '0;
      n_q     <= '0;
      waddr_q <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      nhi_q   <= nhi_d;
      n_q     <= n_d;
      waddr_q <= waddr_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
    end
  end

  // RAM survives reset and reload; only accepted 4th bytes write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: scoreboard of expected RAM words, drained
// through the combinational read port once each image is loaded.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rx_valid, load_req;
  logic [7:0]  rx_data;
  logic [31:0] pc_val, instr;
  logic        rx_ready, cpu_reset, done, err;

  logic        reset4, rx_valid4, load_req4;
  logic [7:0]  rx_data4;
  logic [31:0] pc4, instr4;
  logic        rx_ready4, cpu_reset4, done4, err4;

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .pc_val(pc_val), .instr(instr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .load_req(load_req), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  instr_mem_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset4), .pc_val(pc4), .instr(instr4),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
    .load_req(load_req4), .cpu_reset(cpu_reset4), .done(done4),
    .err(err4)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb4[$];
  logic [31:0] model [256];
  int          checks, errors, stalls;
  logic        pre_crst;

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    load_req = 1'b0;
    while (rx_ready !== 1'b1 && n < 50) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: rx_ready=%b required 1", rx_ready);
    end
    pre_crst = cpu_reset;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic lr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      load_req = lr && (i == 0);
    end
  endtask

  task automatic send_word(input int a, input logic [31:0] w,
                           input int gap, input int mid);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*(3-i) +: 8]);
      if (gap > 0) idle(gap, 1'b0);
      if (i == 1 && mid > 0) idle(mid, 1'b1);
    end
    model[a] = w;
    sb.push_back('{a, w});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    load_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte4(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data4  = b;
    rx_valid4 = 1'b1;
    while (rx_ready4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready4 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_byte4 timeout: rx_ready=%b required 1", rx_ready4);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    load_req = 1'b1;
    pc_val   = 32'h0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL reset rx_ready: got %b want 0", rx_ready);
    end
    checks++;
    if ({cpu_reset, done, err} !== 3'b100) begin
      errors++;
      $display("FAIL reset flags: got crst/done/err=%b want 100",
               {cpu_reset, done, err});
    end
    checks++;
    if (instr !== 32'h0) begin
      errors++; $display("FAIL reset instr: got %h want 0", instr);
    end
    reset    = 1'b0;
    rx_valid = 1'b0;
    load_req = 1'b0;
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL post-reset rx_ready: got %b want 1", rx_ready);
    end
  endtask

  task automatic test_full_rate();
    exp_t e;
    stalls = 0;
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(0, 32'h2008_0005, 0, 0);
    #1;
    checks++;
    if ({cpu_reset, done} !== 2'b10) begin
      errors++;
      $display("FAIL mid-load flags: got crst/done=%b want 10",
               {cpu_reset, done});
    end
    send_word(1, 32'h0800_0000, 0, 0);
    #1;
    checks++;
    if ({pre_crst, cpu_reset, done} !== 3'b101) begin
      errors++;
      $display("FAIL byte10 edge: got pre/crst/done=%b want 101",
               {pre_crst, cpu_reset, done});
    end
    checks++;
    if (stalls !== 0) begin
      errors++; $display("FAIL full-rate stalls: got %0d want 0", stalls);
    end
    idle(1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      pc_val = 32'(e.addr) * 4;
      #1;
      checks++;
      if (instr !== e.data) begin
        errors++;
        $display("FAIL full-rate read @%0d: got %h want %h",
                 e.addr, instr, e.data);
      end
    end
  endtask

  task automatic test_reload_run();
    exp_t e;
    pc_val = 32'h0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checks++;
    if ({cpu_reset, done, rx_ready} !== 3'b101) begin
      errors++;
      $display("FAIL reload entry: got crst/done/ready=%b want 101",
               {cpu_reset, done, rx_ready});
    end
    checks++;
    if (instr !== 32'h0) begin
      errors++; $display("FAIL reload entry instr: got %h want 0", instr);
    end
    send_byte(8'h00);
    send_byte(8'h01);
    #1;
    checks++;
    if (instr !== 32'h0) begin
      errors++; $display("FAIL reload mid instr: got %h want 0", instr);
    end
    send_word(0, 32'h0000_0020, 0, 0);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL reload done: got %b want 1", done);
    end
    sb.push_back('{1, model[1]});
    idle(1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      pc_val = 32'(e.addr) * 4;
      #1;
      checks++;
      if (instr !== e.data) begin
        errors++;
        $display("FAIL reload read @%0d: got %h want %h",
                 e.addr, instr, e.data);
      end
    end
  endtask

  task automatic test_throttled();
    exp_t e;
    do_reset();
    send_byte(8'h00);
    idle(1, 1'b0);
    send_byte(8'h02);
    idle(1, 1'b0);
    send_word(0, 32'h2008_0005, 1, 0);
    send_word(1, 32'h0800_0000, 1, 5);
    checks++;
    if ({done, err, cpu_reset} !== 3'b100) begin
      errors++;
      $display("FAIL throttled flags: got done/err/crst=%b want 100",
               {done, err, cpu_reset});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      pc_val = 32'(e.addr) * 4;
      #1;
      checks++;
      if (instr !== e.data) begin
        errors++;
        $display("FAIL throttled read @%0d: got %h want %h",
                 e.addr, instr, e.data);
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    #1;
    checks++;
    if ({done, cpu_reset} !== 2'b10) begin
      errors++;
      $display("FAIL zero-len flags: got done/crst=%b want 10",
               {done, cpu_reset});
    end
    idle(1, 1'b0);
    pc_val = 32'h0000_0400;
    #1;
    checks++;
    if (instr !== model[0]) begin
      errors++;
      $display("FAIL wrap read: got %h want %h", instr, model[0]);
    end
  endtask

  task automatic test_reset_mid_load();
    exp_t e;
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(0, 32'h1122_3344, 0, 0);
    sb.delete();
    send_byte(8'h55);
    do_reset();
    #1;
    checks++;
    if ({done, cpu_reset} !== 2'b01) begin
      errors++;
      $display("FAIL mid-load reset flags: got done/crst=%b want 01",
               {done, cpu_reset});
    end
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(0, 32'hDEAD_BEEF, 0, 0);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL reload-after-reset done: got %b want 1", done);
    end
    sb.push_back('{1, model[1]});
    idle(1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      pc_val = 32'(e.addr) * 4;
      #1;
      checks++;
      if (instr !== e.data) begin
        errors++;
        $display("FAIL post-abort read @%0d: got %h want %h",
                 e.addr, instr, e.data);
      end
    end
  endtask

  task automatic test_err_depth();
    exp_t        e;
    logic [31:0] w;
    @(negedge clk);
    reset4 = 1'b1;
    @(negedge clk);
    reset4 = 1'b0;
    send_byte4(8'h00);
    send_byte4(8'h11);
    #1;
    checks++;
    if ({err4, rx_ready4, cpu_reset4, done4} !== 4'b1010) begin
      errors++;
      $display("FAIL err flags: got err/ready/crst/done=%b want 1010",
               {err4, rx_ready4, cpu_reset4, done4});
    end
    checks++;
    if (instr4 !== 32'h0) begin
      errors++; $display("FAIL err instr: got %h want 0", instr4);
    end
    @(negedge clk);
    rx_valid4 = 1'b0;
    load_req4 = 1'b1;
    @(negedge clk);
    load_req4 = 1'b0;
    checks++;
    if ({err4, rx_ready4, cpu_reset4} !== 3'b011) begin
      errors++;
      $display("FAIL err clear: got err/ready/crst=%b want 011",
               {err4, rx_ready4, cpu_reset4});
    end
    send_byte4(8'h00);
    send_byte4(8'h10);
    #1;
    checks++;
    if ({err4, rx_ready4} !== 2'b01) begin
      errors++;
      $display("FAIL N=DEPTH accepted: got err/ready=%b want 01",
               {err4, rx_ready4});
    end
    for (int i = 0; i < 16; i++) begin
      w = 32'hA000_0000 + 32'(i) * 32'h0001_0203;
      for (int k = 0; k < 4; k++) send_byte4(w[8*(3-k) +: 8]);
      sb4.push_back('{i, w});
    end
    #1;
    checks++;
    if ({done4, cpu_reset4} !== 2'b10) begin
      errors++;
      $display("FAIL full-depth flags: got done/crst=%b want 10",
               {done4, cpu_reset4});
    end
    @(negedge clk);
    rx_valid4 = 1'b0;
    sb4.push_back('{16, sb4[0].data});
    while (sb4.size() > 0) begin
      e = sb4.pop_front();
      pc4 = 32'(e.addr) * 4;
      #1;
      checks++;
      if (instr4 !== e.data) begin
        errors++;
        $display("FAIL depth4 read @%0d: got %h want %h",
                 e.addr, instr4, e.data);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    stalls    = 0;
    pre_crst  = 1'b0;
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    load_req  = 1'b0;
    pc_val    = 32'h0;
    reset4    = 1'b1;
    rx_valid4 = 1'b0;
    rx_data4  = 8'h00;
    load_req4 = 1'b0;
    pc4       = 32'h0;
    test_reset();
    test_full_rate();
    test_reload_run();
    test_throttled();
    test_zero_len();
    test_reset_mid_load();
    test_err_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
